// File: rtl/vga_pkg.sv
// Shared VGA definitions: arbiter FSM encoding, default position width and
// 1280x720 timing constants used by benches and neighbouring blocks.
package vga_pkg;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        ARB    = 2'd1,
        GRANT  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int PW_DEFAULT = 11;

    localparam int H_ACTIVE = 1280;
    localparam int V_ACTIVE = 720;
    localparam int H_TOTAL  = 1650;
    localparam int V_TOTAL  = 750;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first asserted request at or above ptr,
// wrapping modulo N_REQ. Returns one-hot select, binary index and valid.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] sel,
    output logic [IW-1:0]    idx,
    output logic             valid
);

    // Outer loop is the search order, so the first hit has the highest priority.
    always_comb begin
        sel   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!valid && req[i] && (((int'(ptr) + k) % N_REQ) == i)) begin
                    valid  = 1'b1;
                    sel[i] = 1'b1;
                    idx    = IW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/frame_update_arbiter.sv
// Round-robin arbiter committing object position updates only during vertical
// blanking. Optional FRAME_UPDATE_ARBITER_MISS_EN adds the 'missed' output.
module frame_update_arbiter
    import vga_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int MAX_GNT = 4,
    parameter int PW      = PW_DEFAULT
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              vblnk,
    input  logic [N_REQ-1:0]  req,
    input  logic [N_REQ*PW-1:0] req_x,
    input  logic [N_REQ*PW-1:0] req_y,
    output logic [N_REQ-1:0]  gnt,
    output logic [PW-1:0]     xpos,
    output logic [PW-1:0]     ypos,
    output logic              frame_tick,
`ifdef FRAME_UPDATE_ARBITER_MISS_EN
    output logic              missed,
`endif
    output logic              busy
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t             state_reg, state_next;
    logic               vblnk_d_reg;
    logic [IW-1:0]      ptr_reg;
    logic [3:0]         cnt_reg;
    logic [N_REQ-1:0]   gnt_reg;
    logic [PW-1:0]      xpos_reg, ypos_reg;
    logic               frame_tick_reg;
    logic               busy_reg;

    logic [PW-1:0]      x_lane [N_REQ];
    logic [PW-1:0]      y_lane [N_REQ];
    logic [N_REQ-1:0]   pick_sel;
    logic [IW-1:0]      pick_idx;
    logic               pick_valid;
    logic               rise, fall;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
            assign x_lane[gi] = req_x[gi*PW +: PW];
            assign y_lane[gi] = req_y[gi*PW +: PW];
        end
    endgenerate

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_reg),
        .sel   (pick_sel),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign rise = vblnk & ~vblnk_d_reg;
    assign fall = ~vblnk & vblnk_d_reg;

    // Closing of the window is checked first so a falling vblnk never grants.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ACTIVE: if (rise) state_next = ARB;
            ARB: begin
                if (!vblnk)
                    state_next = ACTIVE;
                else if (cnt_reg == 4'(MAX_GNT))
                    state_next = DONE;
                else if (pick_valid)
                    state_next = GRANT;
            end
            GRANT:  state_next = ARB;
            DONE:   if (fall) state_next = ACTIVE;
            default: state_next = ACTIVE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_reg      <= ACTIVE;
            vblnk_d_reg    <= 1'b0;
            ptr_reg        <= '0;
            cnt_reg        <= '0;
            gnt_reg        <= '0;
            xpos_reg       <= '0;
            ypos_reg       <= '0;
            frame_tick_reg <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            vblnk_d_reg    <= vblnk;
            frame_tick_reg <= fall;
            busy_reg       <= (state_next == ARB) || (state_next == GRANT);
            gnt_reg        <= '0;
            if (state_reg == ACTIVE)
                cnt_reg <= '0;
            if (state_next == GRANT) begin
                gnt_reg  <= pick_sel;
                xpos_reg <= x_lane[pick_idx];
                ypos_reg <= y_lane[pick_idx];
                ptr_reg  <= IW'((int'(pick_idx) + 1) % N_REQ);
                cnt_reg  <= cnt_reg + 4'd1;
            end
        end
    end

`ifdef FRAME_UPDATE_ARBITER_MISS_EN
    logic pend_reg, missed_reg;

    // pend_reg freezes at the last sampled-high cycle, so it is valid at the fall.
    always_ff @(posedge pclk) begin
        if (rst) begin
            pend_reg   <= 1'b0;
            missed_reg <= 1'b0;
        end else begin
            if (vblnk)
                pend_reg <= |(req & ~gnt_reg);
            missed_reg <= fall & pend_reg;
        end
    end

    assign missed = missed_reg;
`endif

    assign gnt        = gnt_reg;
    assign xpos       = xpos_reg;
    assign ypos       = ypos_reg;
    assign frame_tick = frame_tick_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_frame_update_arbiter.sv
// Directed bench for frame_update_arbiter: a MAX_GNT=4 instance and a MAX_GNT=2
// instance share stimulus; inputs change 1 time unit after each rising edge.
module tb_frame_update_arbiter;
    import vga_pkg::*;

    localparam int N = 4;
    localparam int P = PW_DEFAULT;

    logic           pclk = 1'b0;
    logic           rst, vblnk;
    logic [N-1:0]   req;
    logic [N*P-1:0] req_x, req_y;
    logic [N-1:0]   gnt, gnt2;
    logic [P-1:0]   xpos, ypos, xpos2, ypos2;
    logic           frame_tick, frame_tick2, busy, busy2;
`ifdef FRAME_UPDATE_ARBITER_MISS_EN
    logic           missed, missed2;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 pclk = ~pclk;

    frame_update_arbiter #(.N_REQ(N), .MAX_GNT(4), .PW(P)) u_dut (
        .pclk       (pclk),
        .rst        (rst),
        .vblnk      (vblnk),
        .req        (req),
        .req_x      (req_x),
        .req_y      (req_y),
        .gnt        (gnt),
        .xpos       (xpos),
        .ypos       (ypos),
        .frame_tick (frame_tick),
`ifdef FRAME_UPDATE_ARBITER_MISS_EN
        .missed     (missed),
`endif
        .busy       (busy)
    );

    frame_update_arbiter #(.N_REQ(N), .MAX_GNT(2), .PW(P)) u_dut2 (
        .pclk       (pclk),
        .rst        (rst),
        .vblnk      (vblnk),
        .req        (req),
        .req_x      (req_x),
        .req_y      (req_y),
        .gnt        (gnt2),
        .xpos       (xpos2),
        .ypos       (ypos2),
        .frame_tick (frame_tick2),
`ifdef FRAME_UPDATE_ARBITER_MISS_EN
        .missed     (missed2),
`endif
        .busy       (busy2)
    );

    task automatic step(input int n = 1);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
            $display("check %s: observed %0d expected %0d", tag, obs, exp);
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_xy(input int i, input int x, input int y);
        req_x[i*P +: P] = P'(x);
        req_y[i*P +: P] = P'(y);
    endtask

    initial begin
        rst = 1'b1; vblnk = 1'b0; req = '0; req_x = '0; req_y = '0;
        step(3);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_xpos", 32'(xpos), 0);
        chk("rst_ypos", 32'(ypos), 0);
        chk("rst_tick", 32'(frame_tick), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        step(2);

        // Basic commit
        req = 4'b0001; set_xy(0, 100, 50);
        vblnk = 1'b1;
        step;
        chk("basic_arb_busy", 32'(busy), 1);
        chk("basic_arb_gnt", 32'(gnt), 0);
        step;
        chk("basic_gnt", 32'(gnt), 32'b0001);
        chk("basic_xpos", 32'(xpos), 100);
        chk("basic_ypos", 32'(ypos), 50);
        req = '0;
        step(3);
        vblnk = 1'b0;
        chk("basic_tick_pre", 32'(frame_tick), 0);
        step;
        chk("basic_tick", 32'(frame_tick), 1);
        chk("basic_busy_off", 32'(busy), 0);
        step;
        chk("basic_tick_post", 32'(frame_tick), 0);

        // Round robin (MAX_GNT=4) and budget (MAX_GNT=2) from ptr=0
        rst = 1'b1; step; rst = 1'b0;
        for (int i = 0; i < N; i++) set_xy(i, 10 + i, 20 + i);
        req = 4'b1111;
        vblnk = 1'b1;
        for (int i = 0; i < N; i++) begin
            step;
            chk("rr_gap", 32'(gnt), 0);
            step;
            chk("rr_gnt", 32'(gnt), 32'(1 << i));
            chk("rr_xpos", 32'(xpos), 32'(10 + i));
            chk("rr_ypos", 32'(ypos), 32'(20 + i));
            chk("bud_gnt", 32'(gnt2), (i < 2) ? 32'(1 << i) : 0);
            chk("bud_busy", 32'(busy2), (i < 2) ? 1 : 0);
        end
        step;
        chk("rr_last_arb_busy", 32'(busy), 1);
        step;
        chk("rr_done_busy", 32'(busy), 0);
        chk("rr_done_gnt", 32'(gnt), 0);
        step(3);
        chk("rr_done_hold", 32'(gnt), 0);
        chk("bud_done_hold", 32'(gnt2), 0);
        vblnk = 1'b0;
        step;
        chk("rr_tick", 32'(frame_tick), 1);
        chk("bud_tick", 32'(frame_tick2), 1);
        req = '0;
        step(2);

        // Next window for the budget instance resumes at index 2
        req = 4'b1100; vblnk = 1'b1;
        step(2);
        chk("bud_resume", 32'(gnt2), 32'b0100);
        chk("rr_resume", 32'(gnt), 32'b0100);
        req = '0;
        step(2); vblnk = 1'b0; step(2);

        // Request during active video is ignored until the next rise
        set_xy(1, 777, 333); req = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            step;
            chk("gated_gnt", 32'(gnt), 0);
            chk("gated_xpos", 32'(xpos), 12);
        end
        vblnk = 1'b1;
        step;
        chk("gated_arb", 32'(gnt), 0);
        step;
        chk("gated_gnt_rise", 32'(gnt), 32'b0010);
        chk("gated_xpos_rise", 32'(xpos), 777);
        req = '0;
        step(2); vblnk = 1'b0; step(2);

        // Three-cycle window with two requesters: one grant, then ptr=1
        rst = 1'b1; step; rst = 1'b0;
        req = 4'b0011; set_xy(0, 1, 2);
        vblnk = 1'b1;
        step;
        step;
        chk("win_gnt0", 32'(gnt), 32'b0001);
        chk("win_xpos0", 32'(xpos), 1);
        req = 4'b0010;
        step;
        chk("win_gap", 32'(gnt), 0);
        vblnk = 1'b0;
        step;
        chk("win_fall_gnt", 32'(gnt), 0);
        chk("win_tick", 32'(frame_tick), 1);
        chk("win_busy", 32'(busy), 0);
`ifdef FRAME_UPDATE_ARBITER_MISS_EN
        chk("win_missed", 32'(missed), 1);
`endif
        step;
        chk("win_after_gnt", 32'(gnt), 0);
`ifdef FRAME_UPDATE_ARBITER_MISS_EN
        chk("win_missed_off", 32'(missed), 0);
`endif
        step(2);
        vblnk = 1'b1;
        step(2);
        chk("win_next_gnt1", 32'(gnt), 32'b0010);
        chk("win_next_xpos", 32'(xpos), 777);
        req = '0;
        step; vblnk = 1'b0; step(2);

        // Reset on the edge where ARB would select
        req = 4'b0001; set_xy(0, 55, 66);
        vblnk = 1'b1;
        step;
        rst = 1'b1;
        step;
        chk("mrst_gnt", 32'(gnt), 0);
        chk("mrst_xpos", 32'(xpos), 0);
        chk("mrst_ypos", 32'(ypos), 0);
        chk("mrst_busy", 32'(busy), 0);
        rst = 1'b0;
        step;
        chk("mrst_rearm_busy", 32'(busy), 1);
        chk("mrst_rearm_gnt", 32'(gnt), 0);
        step;
        chk("mrst_regnt", 32'(gnt), 32'b0001);
        chk("mrst_rexpos", 32'(xpos), 55);
        req = '0;
        vblnk = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
